// File: rtl/fir_mac_filter.sv
// fir_mac_filter
// Sequential-MAC FIR filter: one multiplier walks the taps, one sample at a
// time. Coefficients are loaded in order through a wrapping write pointer.
// The result is rounded, shifted and saturated to DATA_W.
//
// Ports
//   clk_i, reset_i    : clock and synchronous active-high reset
//   coef_we_i, coef_i : coefficient write, honoured only while idle
//   coef_loaded_o     : all TAPS coefficients written since reset
//   x_valid_i, x_i    : input sample; x_ready_o is high only when idle
//   y_valid_o, y_o    : one-cycle result pulse and held, registered result
//   sat_o             : current y_o was clipped
//   dbg_state_o       : FSM state (0 idle, 1 mac, 2 out)
//
// Handshake: a sample transfers on a rising edge where x_valid_i and
// x_ready_o are both high. x_ready_o depends on the state only, never on
// x_valid_i. y_valid_o has no back-pressure and is high for one cycle.
module fir_mac_filter #(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int TAPS      = 4,
    parameter int OUT_SHIFT = 0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              coef_we_i,
    input  logic [COEF_W-1:0] coef_i,
    output logic              coef_loaded_o,
    input  logic              x_valid_i,
    input  logic [DATA_W-1:0] x_i,
    output logic              x_ready_o,
    output logic              y_valid_o,
    output logic [DATA_W-1:0] y_o,
    output logic              sat_o,
    output logic [1:0]        dbg_state_o
);

    localparam int KW    = $clog2(TAPS);
    localparam int PW    = DATA_W + COEF_W;
    localparam int ACC_W = PW + $clog2(TAPS);
    localparam int RW    = ACC_W + 1;   // one spare bit so the rounding add cannot wrap
    localparam logic [KW-1:0] LAST = KW'(TAPS - 1);
    localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
    localparam logic signed [RW-1:0] RND  = (OUT_SHIFT > 0) ? (RW'(1) <<< RND_SH) : '0;
    localparam logic signed [RW-1:0] MAXV = {{(RW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [RW-1:0] MINV = {{(RW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic signed [COEF_W-1:0]  h_q [TAPS];
    logic signed [COEF_W-1:0]  h_d [TAPS];
    logic signed [DATA_W-1:0]  d_q [TAPS];
    logic signed [DATA_W-1:0]  d_d [TAPS];
    logic [KW-1:0]             wp_q, wp_d;
    logic [KW-1:0]             k_q, k_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      loaded_q, loaded_d;
    logic [DATA_W-1:0]         y_q, y_d;
    logic                      sat_q, sat_d;
    logic                      y_valid_q, y_valid_d;

    logic signed [PW-1:0]      prod;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [RW-1:0]      rnd_sum;
    logic signed [RW-1:0]      rnd_val;
    logic [DATA_W-1:0]         y_val;
    logic                      sat_val;

    // Current tap product and running sum. Operands are sign-extended to
    // the product width so the low PW bits hold the exact signed product.
    always_comb begin
        prod    = PW'(h_q[k_q]) * PW'(d_q[k_q]);
        acc_sum = acc_q + ACC_W'(prod);
    end

    // Round half toward +inf, then clip to the DATA_W signed range.
    // Computed from acc_sum so the result registers on the last MAC edge.
    always_comb begin
        rnd_sum = RW'(acc_sum) + RND;
        rnd_val = rnd_sum >>> OUT_SHIFT;
        sat_val = 1'b0;
        y_val   = rnd_val[DATA_W-1:0];
        if (rnd_val > MAXV) begin
            y_val   = MAXV[DATA_W-1:0];
            sat_val = 1'b1;
        end else if (rnd_val < MINV) begin
            y_val   = MINV[DATA_W-1:0];
            sat_val = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        d_d       = d_q;
        wp_d      = wp_q;
        k_d       = k_q;
        acc_d     = acc_q;
        loaded_d  = loaded_q;
        y_d       = y_q;
        sat_d     = sat_q;
        y_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                // A write and an accept in the same cycle both land; the
                // MAC pass that follows already sees the new coefficient.
                if (coef_we_i) begin
                    h_d[wp_q] = coef_i;
                    if (wp_q == LAST) begin
                        wp_d     = '0;
                        loaded_d = 1'b1;
                    end else begin
                        wp_d = wp_q + KW'(1);
                    end
                end
                if (x_valid_i) begin
                    d_d[0] = x_i;
                    for (int j = 1; j < TAPS; j++) begin
                        d_d[j] = d_q[j-1];
                    end
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_sum;
                k_d   = k_q + KW'(1);
                if (k_q == LAST) begin
                    k_d       = '0;
                    y_d       = y_val;
                    sat_d     = sat_val;
                    y_valid_d = 1'b1;
                    state_d   = OUT;
                end
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            for (int j = 0; j < TAPS; j++) begin
                h_q[j] <= '0;
                d_q[j] <= '0;
            end
            wp_q      <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            loaded_q  <= 1'b0;
            y_q       <= '0;
            sat_q     <= 1'b0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            d_q       <= d_d;
            wp_q      <= wp_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            loaded_q  <= loaded_d;
            y_q       <= y_d;
            sat_q     <= sat_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign x_ready_o     = (state_q == IDLE);
    assign coef_loaded_o = loaded_q;
    assign y_valid_o     = y_valid_q;
    assign y_o           = y_q;
    assign sat_o         = sat_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_fir_mac_filter.sv
// Testbench for fir_mac_filter. Two instances share all inputs: u_dut uses
// OUT_SHIFT=0, u_dut_r uses OUT_SHIFT=2. A behavioural model of the
// coefficient bank and delay line predicts each result when a sample is
// accepted; the monitor pops and compares when y_valid_o pulses.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_fir_mac_filter;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       coef_we_i = 1'b0;
    logic [7:0] coef_i = '0;
    logic       x_valid_i = 1'b0;
    logic [7:0] x_i = '0;

    logic       coef_loaded_o, x_ready_o, y_valid_o, sat_o;
    logic [7:0] y_o;
    logic [1:0] dbg_state_o;
    logic       loaded_r, ready_r, y_valid_r, sat_r;
    logic [7:0] y_r;
    logic [1:0] dbg_r;

    fir_mac_filter #(.DATA_W(8), .COEF_W(8), .TAPS(4), .OUT_SHIFT(0)) u_dut (
        .clk_i(clk), .reset_i(reset_i), .coef_we_i(coef_we_i), .coef_i(coef_i),
        .coef_loaded_o(coef_loaded_o), .x_valid_i(x_valid_i), .x_i(x_i),
        .x_ready_o(x_ready_o), .y_valid_o(y_valid_o), .y_o(y_o), .sat_o(sat_o),
        .dbg_state_o(dbg_state_o)
    );

    fir_mac_filter #(.DATA_W(8), .COEF_W(8), .TAPS(4), .OUT_SHIFT(2)) u_dut_r (
        .clk_i(clk), .reset_i(reset_i), .coef_we_i(coef_we_i), .coef_i(coef_i),
        .coef_loaded_o(loaded_r), .x_valid_i(x_valid_i), .x_i(x_i),
        .x_ready_o(ready_r), .y_valid_o(y_valid_r), .y_o(y_r), .sat_o(sat_r),
        .dbg_state_o(dbg_r)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- model and scoreboard ----------------
    logic signed [7:0] m_h [4];
    logic signed [7:0] m_d [4];
    int                m_wp;
    bit                m_loaded;
    logic [8:0]        exp_q[$];    // {sat, y} for OUT_SHIFT=0
    logic [8:0]        exp_r_q[$];  // {sat, y} for OUT_SHIFT=2
    int                t_q[$];      // accept cycle

    function automatic logic [8:0] model_out(input int acc, input int s);
        int r;
        logic [31:0] rv;
        r = (s > 0) ? ((acc + (1 << (s - 1))) >>> s) : acc;
        if (r > 127) return {1'b1, 8'h7f};
        if (r < -128) return {1'b1, 8'h80};
        rv = r;
        return {1'b0, rv[7:0]};
    endfunction

    task automatic model_clear();
        for (int j = 0; j < 4; j++) begin
            m_h[j] = '0;
            m_d[j] = '0;
        end
        m_wp = 0;
        m_loaded = 1'b0;
        exp_q.delete();
        exp_r_q.delete();
        t_q.delete();
    endtask

    task automatic model_write(input logic [7:0] c);
        m_h[m_wp] = c;
        if (m_wp == 3) begin
            m_wp = 0;
            m_loaded = 1'b1;
        end else begin
            m_wp++;
        end
    endtask

    task automatic model_accept(input logic [7:0] x);
        int acc;
        for (int j = 3; j > 0; j--) m_d[j] = m_d[j-1];
        m_d[0] = x;
        acc = 0;
        for (int j = 0; j < 4; j++) acc += int'(m_h[j]) * int'(m_d[j]);
        exp_q.push_back(model_out(acc, 0));
        exp_r_q.push_back(model_out(acc, 2));
        t_q.push_back(cyc);
    endtask

    // ---------------- monitor ----------------
    logic [8:0] mon_e, mon_er;
    int         mon_t;
    bit         prev_v = 1'b0;

    always @(negedge clk) begin
        if (reset_i) begin
            prev_v = 1'b0;
        end else begin
            if (y_valid_o) begin
                check("valid_pulse", {31'b0, prev_v}, 0);
                check("r_valid", {31'b0, y_valid_r}, 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    mon_e  = exp_q.pop_front();
                    mon_er = exp_r_q.pop_front();
                    mon_t  = t_q.pop_front();
                    check("y", {24'b0, y_o}, {24'b0, mon_e[7:0]});
                    check("sat", {31'b0, sat_o}, {31'b0, mon_e[8]});
                    check("y_r", {24'b0, y_r}, {24'b0, mon_er[7:0]});
                    check("sat_r", {31'b0, sat_r}, {31'b0, mon_er[8]});
                    check("latency", cyc - mon_t, 5);
                end
            end
            prev_v = y_valid_o;
        end
    end

    // ---------------- driver tasks (called just after a falling edge) ----------------
    task automatic do_reset();
        exp_q.delete();
        exp_r_q.delete();
        t_q.delete();
        reset_i   = 1'b1;
        x_valid_i = 1'b0;
        coef_we_i = 1'b0;
        repeat (2) @(negedge clk);
        model_clear();
        check("rst_y", {24'b0, y_o}, 0);
        check("rst_valid", {31'b0, y_valid_o}, 0);
        check("rst_sat", {31'b0, sat_o}, 0);
        check("rst_loaded", {31'b0, coef_loaded_o}, 0);
        check("rst_loaded_r", {31'b0, loaded_r}, 0);
        check("rst_state", {30'b0, dbg_state_o}, 0);
        check("rst_state_r", {30'b0, dbg_r}, 0);
        reset_i = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'b0, x_ready_o}, 1);
        check("rst_ready_r", {31'b0, ready_r}, 1);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!x_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("ready_timeout", {31'b0, x_ready_o}, 1);
    endtask

    task automatic wr_coef(input logic [7:0] c);
        wait_ready();
        coef_we_i = 1'b1;
        coef_i    = c;
        model_write(c);
        @(negedge clk);
        coef_we_i = 1'b0;
        check("loaded", {31'b0, coef_loaded_o}, {31'b0, m_loaded});
    endtask

    // Write strobe with no wait and no model update: used to hit MAC.
    task automatic wr_raw(input logic [7:0] c);
        coef_we_i = 1'b1;
        coef_i    = c;
        @(negedge clk);
        coef_we_i = 1'b0;
    endtask

    task automatic send(input logic [7:0] x, input bit wc, input logic [7:0] c);
        wait_ready();
        x_valid_i = 1'b1;
        x_i       = x;
        if (wc) begin
            coef_we_i = 1'b1;
            coef_i    = c;
            model_write(c);
        end
        model_accept(x);
        @(negedge clk);
        x_valid_i = 1'b0;
        coef_we_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
        @(negedge clk);
    endtask

    // Hold x_valid_i high and require accepts exactly 6 cycles apart.
    task automatic stream(input int count);
        int n = 0;
        int acc_cnt = 0;
        int last = -1;
        x_valid_i = 1'b1;
        while (acc_cnt < count && n < 100) begin
            if (x_ready_o) begin
                x_i = 8'($urandom_range(0, 255));
                model_accept(x_i);
                if (last >= 0) check("accept_gap", cyc - last, 6);
                last = cyc;
                acc_cnt++;
            end
            @(negedge clk);
            n++;
        end
        x_valid_i = 1'b0;
        if (acc_cnt < count) check("stream_timeout", acc_cnt, count);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        @(negedge clk);
        do_reset();

        // Load and impulse
        wr_coef(8'd1); wr_coef(8'd2); wr_coef(8'd3); wr_coef(8'd4);
        send(8'd1, 0, 0);
        repeat (4) send(8'd0, 0, 0);
        drain();

        // Step with -1
        send(8'hff, 0, 0);
        repeat (4) send(8'd0, 0, 0);
        drain();

        // Saturation both ways, then an in-range result
        repeat (4) wr_coef(8'd127);
        repeat (4) send(8'd127, 0, 0);
        repeat (4) send(8'h80, 0, 0);
        drain();
        repeat (4) wr_coef(8'd0);
        send(8'd3, 0, 0);
        drain();

        // Rounding (second instance): h = 1,0,0,0
        wr_coef(8'd1);
        send(8'd6, 0, 0);
        send(8'hfa, 0, 0);
        send(8'd5, 0, 0);
        drain();

        // Continuous valid, random samples
        stream(4);
        drain();

        // Write during MAC is dropped: h and wp unchanged
        send(8'($urandom_range(0, 255)), 0, 0);
        wr_raw(8'd99);
        drain();
        wr_coef(8'd5);          // lands at wp=1 if the dropped write left wp alone
        send(8'd1, 0, 0);
        repeat (3) send(8'd0, 0, 0);
        drain();

        // Write in the same cycle as an accept is used in that result
        send(8'd1, 0, 0);
        send(8'd0, 1, 8'd7);
        drain();

        // Reset in cycle t+2 after an accept
        send(8'd9, 0, 0);
        @(negedge clk);
        do_reset();
        repeat (8) begin
            check("no_valid", {31'b0, y_valid_o}, 0);
            @(negedge clk);
        end
        check("post_rst_loaded", {31'b0, coef_loaded_o}, 0);
        send(8'd1, 0, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fir_mac_filter.md
# fir_mac_filter

Parametrised, sequential-MAC FIR filter for the digital filter datapath. It is the generalised successor of the fixed 8-bit, 4-tap filter: tap count, data and coefficient widths, and output scaling are parameters. It adds a ready/valid sample handshake, addressed-by-order coefficient loading with a loaded flag, rounding, and saturation with a flag. It uses a single multiplier that iterates over the taps, trading throughput for area.

## Interface
- `DATA_W`, 8, sample and output width, signed two's complement
- `COEF_W`, 8, coefficient width, signed two's complement
- `TAPS`, 4, number of taps, ≥2
- `OUT_SHIFT`, 0, arithmetic right shift applied to the accumulator before saturation, 0..`COEF_W`+clog2(`TAPS`)

Ports:
- `clk_i` in 1: single clock, all logic on rising edge
- `reset_i` in 1: synchronous, active-high reset
- `coef_we_i` in 1: coefficient write strobe
- `coef_i` in `COEF_W`: coefficient value written at the pointer
- `coef_loaded_o` out 1: high once `TAPS` coefficients have been written since reset
- `x_valid_i` in 1: input sample valid
- `x_i` in `DATA_W`: input sample
- `x_ready_o` out 1: filter can accept a sample; high only in IDLE
- `y_valid_o` out 1: one-cycle pulse, `y_o` is a new result
- `y_o` out `DATA_W`: filtered output, registered, held between results
- `sat_o` out 1: the current `y_o` was clipped; updates with `y_valid_o`

## Operation
- **State.**
  - Coefficient bank `h[0..TAPS-1]`.
  - Delay line `d[0..TAPS-1]`.
  - Coefficient write pointer `wp`, from 0 to `TAPS`-1.
  - Accumulator `acc` of `ACC_W` = `DATA_W`+`COEF_W`+clog2(`TAPS`) bits, signed.
  - Tap index `k`.
  - FSM with states IDLE, MAC, OUT.
- **Reset.** While `reset_i` is high, all inputs are ignored. At reset:
  - `h`, `d`, `acc`, `wp` and `k` clear to 0; the FSM goes to IDLE.
  - Outputs: `y_o`=0, `y_valid_o`=0, `sat_o`=0, `coef_loaded_o`=0.
  - `x_ready_o` is 1 from the first cycle after reset.
- **Coefficient load.**
  - A write is honoured only in IDLE: `h[wp]` ← `coef_i`, then `wp` increments and wraps from `TAPS`-1 to 0.
  - Writes in MAC or OUT are silently dropped, and `wp` does not move.
  - `coef_loaded_o` sets on the write to `wp`=`TAPS`-1 and stays set until reset.
  - After a wrap, further writes overwrite `h[0]`, `h[1]`, and so on.
  - Unloaded taps are 0. Samples are processed even when `coef_loaded_o`=0.
- **Sample accept.** A sample is accepted when `x_valid_i` and `x_ready_o` are both high in IDLE.
  - The delay line shifts: `d[0]`←`x_i`, `d[j]`←`d[j-1]`.
  - `acc`←0, `k`←0, and the FSM goes to MAC.
- **Simultaneous coefficient write and sample accept in IDLE.** Both take effect in the same cycle. The new coefficient is used by the computation that starts on the next cycle.
- **MAC.** Each cycle, `acc` += `h[k]`·`d[k]` (full-precision signed product, sign-extended) and `k` increments. After the product for `k`=`TAPS`-1, the FSM goes to OUT.
- **OUT.**
  - Rounding: if `OUT_SHIFT`>0, `r` = (`acc` + 2^(`OUT_SHIFT`-1)) >>> `OUT_SHIFT` (round half toward +∞); otherwise `r`=`acc`.
  - Saturation: if `r` > 2^(`DATA_W`-1)-1, `y_o` takes the max and `sat_o`=1. If `r` < -2^(`DATA_W`-1), `y_o` takes the min and `sat_o`=1. Otherwise `y_o`=`r` and `sat_o`=0.
  - `y_valid_o`=1 for this cycle; the FSM returns to IDLE.
- **Reset mid-operation.** Aborts any MAC or OUT; no `y_valid_o` pulse is produced. Coefficients are lost.

## Timing
- Sample accepted at the edge ending cycle t; MAC runs in cycles t+1 … t+`TAPS`.
- Registered `y_o`, `sat_o` and `y_valid_o` are visible in cycle t+`TAPS`+1.
- `x_ready_o` returns high in cycle t+`TAPS`+2. Throughput is one sample per `TAPS`+2 cycles; default latency is 5 cycles to valid.
- `x_ready_o` is combinational from the state (IDLE) and does not depend on `x_valid_i`.
- `y_valid_o` is never high for two consecutive cycles.

## Test plan
- **Load and impulse.** Reset, load `h`=1,2,3,4 (`wp` wraps to 0; `coef_loaded_o` rises after the 4th write). Send samples 1,0,0,0,0 → `y_o`=1,2,3,4,0, `sat_o`=0. Each `y_valid_o` pulse arrives 5 cycles after its accept.
- **Step from the tb stimulus.** Same `h`, send 0xFF (-1) then 0x00 repeated → `y_o`=-1,-2,-3,-4,0 in sequence after the -1 leaves the line: outputs 0xFF, 0xFE, 0xFD, 0xFC, 0x00.
- **Saturation.**
  - `h`=127 ×4 and `x`=127 ×4 → final `y_o`=127, `sat_o`=1.
  - `h`=127 ×4 and `x`=-128 ×4 → final `y_o`=-128, `sat_o`=1.
  - A subsequent in-range result clears `sat_o`.
- **Rounding** (`OUT_SHIFT`=2, `h`=1,0,0,0):
  - `x`=6 → `y_o`=2
  - `x`=-6 → `y_o`=-1
  - `x`=5 → `y_o`=1
- **Handshake and drop.**
  - Hold `x_valid_i` high continuously → accepts occur exactly every 6 cycles.
  - A `coef_we_i` issued during MAC → `h` unchanged, `wp` unchanged.
  - A write issued in the same IDLE cycle as an accept → the new coefficient is used in that result.
- **Reset mid-MAC.** Assert `reset_i` in cycle t+2 after an accept → no `y_valid_o`, `y_o`=0, `coef_loaded_o`=0. The next impulse yields 0 (coefficients cleared).
